// File: rtl/cpu_isa_pkg.sv
// Shared wide-immediate ISA definitions: opcodes, the zero register and
// the sequencing states used by the immediate-load encoder.
package cpu_isa_pkg;

    // 9-bit wide-immediate (move-wide) opcodes, 64-bit forms
    localparam logic [8:0] OP_MOVN = 9'b100100101;
    localparam logic [8:0] OP_MOVZ = 9'b110100101;
    localparam logic [8:0] OP_MOVK = 9'b111100101;

    // Writes to this register are discarded, so loading it is meaningless
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT_Z = 2'd1,
        ST_EMIT_K = 2'd2,
        ST_DONE   = 2'd3
    } enc_state_t;

    // Bit i is set when halfword i of the value is nonzero
    function automatic logic [3:0] nonzero_mask(input logic [63:0] value);
        logic [3:0] m;
        for (int unsigned i = 0; i < 4; i++) begin
            m[i] = (value[16*i +: 16] != 16'h0000);
        end
        return m;
    endfunction

endpackage

// File: rtl/imm64_load_encoder_pick.sv
// Lowest-set-bit picker over the 4-bit pending-halfword mask.
// An empty mask yields index 0 and an all-zero clear vector.
module halfword_priority_pick (
    input  logic [3:0] mask,
    output logic [1:0] idx,
    output logic [3:0] clr
);

    // Priority encode from bit 0 upward
    always_comb begin
        idx = '0;
        clr = '0;
        if (mask[0]) begin
            idx = 2'd0;
            clr = 4'b0001;
        end else if (mask[1]) begin
            idx = 2'd1;
            clr = 4'b0010;
        end else if (mask[2]) begin
            idx = 2'd2;
            clr = 4'b0100;
        end else if (mask[3]) begin
            idx = 2'd3;
            clr = 4'b1000;
        end
    end

endmodule

// File: rtl/imm64_load_encoder.sv
// Streams the shortest MOVZ/MOVK sequence that rebuilds a 64-bit constant
// in a destination register. Word outputs derive only from registered
// state, so they stay stable while the consumer stalls.
module imm64_load_encoder #(
    parameter logic       SKIP_ZERO = 1'b1,
    parameter logic [8:0] OP_MOVZ   = cpu_isa_pkg::OP_MOVZ,
    parameter logic [8:0] OP_MOVK   = cpu_isa_pkg::OP_MOVK
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_value,
    input  logic [4:0]  req_rd,
    output logic        iw_valid,
    input  logic        iw_ready,
    output logic [31:0] iw,
    output logic        iw_last,
    output logic        done,
    output logic        err,
    output logic [2:0]  iw_count
);
    import cpu_isa_pkg::*;

    enc_state_t  state, state_next;
    logic [63:0] value_q;
    logic [4:0]  rd_q;
    logic [3:0]  mask_q;
    logic [2:0]  count_q;
    logic [2:0]  iw_count_q;
    logic        err_q;

    logic [1:0]  pick_idx;
    logic [3:0]  pick_clr;
    logic [3:0]  mask_after;
    logic [15:0] hw_data;
    logic        accept;
    logic        fire;

    halfword_priority_pick u_pick (
        .mask (mask_q),
        .idx  (pick_idx),
        .clr  (pick_clr)
    );

    assign mask_after = mask_q & ~pick_clr;
    assign accept     = req_valid && req_ready;
    assign fire       = iw_valid && iw_ready;
    assign iw_count   = iw_count_q;

    // Select the halfword addressed by the picked index
    always_comb begin
        hw_data = '0;
        case (pick_idx)
            2'd0: hw_data = value_q[15:0];
            2'd1: hw_data = value_q[31:16];
            2'd2: hw_data = value_q[47:32];
            2'd3: hw_data = value_q[63:48];
            default: hw_data = '0;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/word outputs
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        iw_valid   = 1'b0;
        iw         = '0;
        iw_last    = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (req_rd == ZERO_REG) ? ST_DONE : ST_EMIT_Z;
                end
            end
            ST_EMIT_Z, ST_EMIT_K: begin
                iw_valid = 1'b1;
                iw       = {(state == ST_EMIT_Z) ? OP_MOVZ : OP_MOVK,
                            pick_idx, hw_data, rd_q};
                // An empty mask on MOVZ is the value==0 case: a single word
                iw_last  = (mask_after == 4'b0000);
                if (iw_ready) begin
                    if (mask_after == 4'b0000) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_EMIT_K;
                    end
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                err        = err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, pending mask, word counter and reported count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value_q    <= '0;
            rd_q       <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            iw_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                value_q <= req_value;
                rd_q    <= req_rd;
                count_q <= '0;
                // Without skipping, MOVZ covers hw0 and MOVK covers hw1..3
                mask_q  <= SKIP_ZERO ? nonzero_mask(req_value) : 4'b1111;
                err_q   <= (req_rd == ZERO_REG);
                if (req_rd == ZERO_REG) begin
                    iw_count_q <= '0;
                end
            end else if (fire) begin
                mask_q  <= mask_after;
                count_q <= count_q + 3'd1;
                if (mask_after == 4'b0000) begin
                    iw_count_q <= count_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imm64_load_encoder.sv
// Directed self-checking bench for imm64_load_encoder.
module tb_imm64_load_encoder;

    localparam logic [8:0] OPZ = 9'b110100101;
    localparam logic [8:0] OPK = 9'b111100101;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_value;
    logic [4:0]  req_rd;
    logic        iw_valid;
    logic        iw_ready;
    logic [31:0] iw;
    logic        iw_last;
    logic        done;
    logic        err;
    logic [2:0]  iw_count;

    int checks = 0;
    int errors = 0;

    imm64_load_encoder #(.SKIP_ZERO(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .req_rd    (req_rd),
        .iw_valid  (iw_valid),
        .iw_ready  (iw_ready),
        .iw        (iw),
        .iw_last   (iw_last),
        .done      (done),
        .err       (err),
        .iw_count  (iw_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [8:0] op, input logic [1:0] hw,
                                       input logic [15:0] imm, input logic [4:0] rd);
        return {op, hw, imm, rd};
    endfunction

    // Present a request at the current falling edge; returns one cycle later
    task automatic send(input logic [63:0] v, input logic [4:0] rd);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_value = v;
        req_rd    = rd;
        @(negedge clock);
        req_valid = 1'b0;
        req_value = '0;
        req_rd    = '0;
    endtask

    // Drain n words with a repeating 4-cycle ready pattern, then check done
    task automatic collect(input string tag, input int n,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input logic [3:0] pat, input logic [2:0] cnt);
        logic [31:0] exp_w [4];
        logic [31:0] prev_iw;
        logic        prev_last;
        logic        stalled;
        int          got;
        int unsigned k;
        exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
        got = 0; k = 0; stalled = 1'b0; prev_iw = '0; prev_last = 1'b0;
        while (got < n && k < 40) begin
            iw_ready = pat[k % 4];
            chk({tag, "_iw_valid"}, iw_valid, 1);
            if (stalled) begin
                chk({tag, "_stall_iw"}, iw, prev_iw);
                chk({tag, "_stall_last"}, iw_last, prev_last);
            end
            if (iw_ready) begin
                chk({tag, "_iw"}, iw, exp_w[got]);
                chk({tag, "_iw_last"}, iw_last, (got == n - 1));
                got++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                prev_iw   = iw;
                prev_last = iw_last;
            end
            k++;
            @(negedge clock);
        end
        iw_ready = 1'b0;
        chk({tag, "_words_done"}, got, n);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_valid_off"}, iw_valid, 0);
        chk({tag, "_ready_off"}, req_ready, 0);
        chk({tag, "_count"}, iw_count, cnt);
        @(negedge clock);
        chk({tag, "_done_1cyc"}, done, 0);
        chk({tag, "_count_held"}, iw_count, cnt);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_value = '0;
        req_rd    = '0;
        iw_ready  = 1'b0;
        repeat (2) @(negedge clock);

        chk("rst_req_ready", req_ready, 1);
        chk("rst_iw_valid", iw_valid, 0);
        chk("rst_iw", iw, 0);
        chk("rst_iw_last", iw_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_iw_count", iw_count, 0);
        reset = 1'b0;
        @(negedge clock);

        // Single nonzero low halfword
        send(64'h0000_0000_0000_1234, 5'd3);
        collect("t1", 1, 32'hD2824683, '0, '0, '0, 4'b1111, 3'd1);
        checks++;
        assert (mk(OPZ, 2'd0, 16'h1234, 5'd3) === 32'hD2824683) else begin
            errors++;
            $error("FAIL t1_hand_encoding observed=%0h expected=%0h",
                   mk(OPZ, 2'd0, 16'h1234, 5'd3), 32'hD2824683);
        end

        // Two sparse halfwords, back-to-back
        send(64'hDEAD_0000_BEEF_0000, 5'd7);
        collect("t2", 2, mk(OPZ, 2'd1, 16'hBEEF, 5'd7), mk(OPK, 2'd3, 16'hDEAD, 5'd7),
                '0, '0, 4'b1111, 3'd2);

        // Zero value still emits one MOVZ
        send(64'h0, 5'd5);
        collect("t3", 1, mk(OPZ, 2'd0, 16'h0000, 5'd5), '0, '0, '0, 4'b1111, 3'd1);

        // All four halfwords with stalls (ready pattern 1,0,0,1)
        send(64'h1111_2222_3333_4444, 5'd9);
        collect("t4", 4, mk(OPZ, 2'd0, 16'h4444, 5'd9), mk(OPK, 2'd1, 16'h3333, 5'd9),
                mk(OPK, 2'd2, 16'h2222, 5'd9), mk(OPK, 2'd3, 16'h1111, 5'd9),
                4'b1001, 3'd4);

        // Zero register rejected
        send(64'hFFFF_FFFF_FFFF_FFFF, 5'd31);
        chk("t5_no_valid", iw_valid, 0);
        chk("t5_done", done, 1);
        chk("t5_err", err, 1);
        chk("t5_count", iw_count, 0);
        @(negedge clock);
        chk("t5_done_clear", done, 0);
        chk("t5_err_clear", err, 0);
        chk("t5_ready_back", req_ready, 1);

        // Reset during the second word
        send(64'h1111_2222_3333_4444, 5'd9);
        iw_ready = 1'b1;
        chk("t6_first", iw, mk(OPZ, 2'd0, 16'h4444, 5'd9));
        @(negedge clock);
        iw_ready = 1'b0;
        chk("t6_second", iw, mk(OPK, 2'd1, 16'h3333, 5'd9));
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", iw_valid, 0);
        chk("t6_rst_ready", req_ready, 1);
        chk("t6_rst_iw", iw, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_no_done", done, 0);
            chk("t6_idle_valid", iw_valid, 0);
            @(negedge clock);
        end
        send(64'h1111_2222_3333_4444, 5'd2);
        collect("t6_retry", 4, mk(OPZ, 2'd0, 16'h4444, 5'd2), mk(OPK, 2'd1, 16'h3333, 5'd2),
                mk(OPK, 2'd2, 16'h2222, 5'd2), mk(OPK, 2'd3, 16'h1111, 5'd2),
                4'b1111, 3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the bench always ends
    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
